// File: rtl/inst_prefetch_pkg.sv
// Shared constants and the queued {pc, inst} entry type for the instruction prefetch queue.
package inst_prefetch_pkg;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] inst;
  } entry_t;

endpackage

// File: rtl/inst_prefetch_queue_fifo.sv
// Circular buffer of prefetched entries with push, pop and a clear that wins over both.
module prefetch_fifo
  import inst_prefetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  entry_t           data_i,
  output entry_t           head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
    count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; entries are only visible once count says they are valid.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: sequential fetch with credit-limited requests and redirect flush.
// Optional `INST_PREFETCH_STATS_EN adds a saturating flush_count of discarded words.
module inst_prefetch_queue
  import inst_prefetch_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic [AW-1:0] mem_req_addr,
  input  logic          mem_rsp_valid,
  input  logic [DW-1:0] mem_rsp_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_inst,
  output logic [AW-1:0] out_pc
`ifdef INST_PREFETCH_STATS_EN
  ,
  output logic [15:0]   flush_count
`endif
);

  logic             active_q;
  logic [AW-1:0]    fetch_pc_q, fetch_pc_d;
  logic [AW-1:0]    pc_tag_q, pc_tag_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   in_use;
  logic             req_fire, rsp_drop, push, pop, empty;
  entry_t           head, push_entry;

  // Queued plus outstanding words may never exceed DEPTH, so a push always finds room.
  assign in_use        = {1'b0, count} + {1'b0, outstanding_q};
  assign mem_req_valid = active_q & en & ~redirect_valid & (in_use < (CNT_W+1)'(DEPTH));
  assign mem_req_addr  = fetch_pc_q;
  assign req_fire      = mem_req_valid & mem_req_ready;

  // A response in the redirect cycle belongs to the old stream and is discarded.
  assign rsp_drop   = mem_rsp_valid & ((drop_q != '0) | redirect_valid);
  assign push       = mem_rsp_valid & ~rsp_drop;
  assign pop        = out_valid & out_ready & ~redirect_valid;
  assign push_entry = '{pc: pc_tag_q, inst: mem_rsp_data};

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    fetch_pc_d    = fetch_pc_q + AW'(req_fire);
    pc_tag_d      = pc_tag_q + AW'(push);
    outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(mem_rsp_valid);
    drop_d        = drop_q - CNT_W'(rsp_drop);
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      pc_tag_d   = redirect_pc;
      drop_d     = outstanding_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q      <= 1'b0;
      fetch_pc_q    <= '0;
      pc_tag_q      <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      active_q      <= 1'b1;
      fetch_pc_q    <= fetch_pc_d;
      pc_tag_q      <= pc_tag_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  prefetch_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (redirect_valid),
    .data_i  (push_entry),
    .head_o  (head),
    .count_o (count),
    .empty_o (empty)
  );

  assign out_valid = ~empty;
  assign out_inst  = head.inst;
  assign out_pc    = head.pc;

`ifdef INST_PREFETCH_STATS_EN
  logic [15:0] flush_count_q, flush_count_d;
  logic [16:0] flush_sum;

  always_comb begin
    flush_sum     = {1'b0, flush_count_q} + 17'(rsp_drop)
                  + (redirect_valid ? 17'(count) : 17'd0);
    flush_count_d = flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flush_count_q <= '0;
    else        flush_count_q <= flush_count_d;
  end

  assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed bench for inst_prefetch_queue with a fixed-latency memory model (inst = ~addr).
module tb_inst_prefetch_queue;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
`ifdef INST_PREFETCH_STATS_EN
  logic [15:0] flush_count;
`endif

  int          n_assert;
  int          n_fail;
  int          acc_count;
  int          cyc;
  int          lat;
  int          due_q[$];
  logic [31:0] addr_q[$];

  inst_prefetch_queue dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc)
`ifdef INST_PREFETCH_STATS_EN
    ,
    .flush_count    (flush_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] inst_of(logic [31:0] a);
    return ~a;
  endfunction

  task automatic check_b(string tag, logic obs, logic exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_w(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample the request handshake mid-cycle, then present due responses.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    @(negedge clk);
    acc = mem_req_valid & mem_req_ready;
    a   = mem_req_addr;
    if (acc) acc_count++;
    @(posedge clk);
    #1;
    if (acc) begin
      due_q.push_back(cyc + lat);
      addr_q.push_back(a);
    end
    cyc++;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = inst_of(addr_q[0]);
      void'(due_q.pop_front());
      void'(addr_q.pop_front());
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end
  endtask

  // Asynchronous reset mid-run; returns at the first cycle with the fetcher active.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_b("async_rst_out_valid", out_valid, 1'b0);
    check_w("async_rst_req_addr", mem_req_addr, 32'h0);
    check_w("async_rst_out_pc", out_pc, 32'h0);
    due_q.delete();
    addr_q.delete();
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = '0;
    redirect_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    acc_count = 0;
  endtask

  initial begin
    n_assert = 0; n_fail = 0; acc_count = 0; cyc = 0; lat = 1;
    rst_n = 1'b0; en = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0; out_ready = 1'b1;

    // Reset values
    @(posedge clk);
    #1;
    check_b("rst_req_valid", mem_req_valid, 1'b0);
    check_w("rst_req_addr", mem_req_addr, 32'h0);
    check_b("rst_out_valid", out_valid, 1'b0);
    check_w("rst_out_inst", out_inst, 32'h0);
    check_w("rst_out_pc", out_pc, 32'h0);
`ifdef INST_PREFETCH_STATS_EN
    check_w("rst_flush", {16'h0, flush_count}, 32'h0);
`endif

    // Streaming: one request per cycle, data two cycles after accept
    rst_n = 1'b1;
    #1;
    check_b("inactive_req_valid", mem_req_valid, 1'b0);
    tick();
    check_b("c1_req_valid", mem_req_valid, 1'b1);
    check_w("c1_req_addr", mem_req_addr, 32'h0);
    tick();
    check_w("c2_req_addr", mem_req_addr, 32'h1);
    check_b("c2_out_valid", out_valid, 1'b0);
    tick();
    check_b("c3_out_valid", out_valid, 1'b1);
    check_w("c3_out_pc", out_pc, 32'h0);
    check_w("c3_out_inst", out_inst, inst_of(32'h0));
    check_w("c3_req_addr", mem_req_addr, 32'h2);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_w("stream_out_pc", out_pc, k);
      check_w("stream_out_inst", out_inst, inst_of(k));
      check_w("stream_req_addr", mem_req_addr, k + 2);
    end

    // Back-pressure: credit stops requests at DEPTH
    out_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 10; k++) tick();
    check_w("full_accepts", acc_count, 32'd4);
    check_b("full_req_valid", mem_req_valid, 1'b0);
    check_b("full_out_valid", out_valid, 1'b1);
    check_w("full_out_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    acc_count = 0;
    for (int k = 0; k < 6; k++) tick();
    check_w("refill_accepts", acc_count, 32'd1);
    check_w("refill_out_pc", out_pc, 32'h1);
    check_b("refill_req_valid", mem_req_valid, 1'b0);

    // Redirect with 2 queued and 2 in flight (2-cycle memory)
    lat = 2;
    do_reset();
    for (int k = 0; k < 4; k++) tick();
    check_b("pre_redir_out_valid", out_valid, 1'b1);
    check_w("pre_redir_out_pc", out_pc, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    #1;
    check_b("redir_req_valid", mem_req_valid, 1'b0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check_b("post_redir_out_valid", out_valid, 1'b0);
    check_b("post_redir_req_valid", mem_req_valid, 1'b1);
    check_w("post_redir_req_addr", mem_req_addr, 32'h40);
`ifdef INST_PREFETCH_STATS_EN
    check_w("redir_flush_r1", {16'h0, flush_count}, 32'd3);
`endif
    out_ready = 1'b1;
    tick();
    check_b("redir_drop1_out_valid", out_valid, 1'b0);
`ifdef INST_PREFETCH_STATS_EN
    check_w("redir_flush_r2", {16'h0, flush_count}, 32'd4);
`endif
    tick();
    check_b("redir_drop2_out_valid", out_valid, 1'b0);
    tick();
    check_b("redir_new_out_valid", out_valid, 1'b1);
    check_w("redir_new_out_pc", out_pc, 32'h40);
    check_w("redir_new_out_inst", out_inst, inst_of(32'h40));

    // Request stall: address held until accepted
    lat = 1;
    mem_req_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      check_b("stall_req_valid", mem_req_valid, 1'b1);
      check_w("stall_req_addr", mem_req_addr, 32'h0);
      tick();
    end
    check_w("stall_no_accept", acc_count, 32'd0);
    mem_req_ready = 1'b1;
    #1;
    check_w("stall_accept_addr", mem_req_addr, 32'h0);
    tick();
    check_w("stall_next_addr", mem_req_addr, 32'h1);
    check_w("stall_accepts", acc_count, 32'd1);

    // Redirect coinciding with response, pop and request
    tick();
    check_b("coinc_out_valid", out_valid, 1'b1);
    check_b("coinc_rsp_valid", mem_rsp_valid, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    #1;
    check_b("coinc_req_valid", mem_req_valid, 1'b0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check_w("coinc_no_request", acc_count, 32'd2);
    check_b("coinc_out_valid_after", out_valid, 1'b0);
    check_w("coinc_req_addr", mem_req_addr, 32'h100);
`ifdef INST_PREFETCH_STATS_EN
    check_w("coinc_flush", {16'h0, flush_count}, 32'd2);
`endif
    tick();
    check_b("coinc_gap_out_valid", out_valid, 1'b0);
    tick();
    check_w("coinc_new_out_pc", out_pc, 32'h100);
    check_w("coinc_new_out_inst", out_inst, inst_of(32'h100));

    // Address wrap
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    #1;
    check_w("wrap_addr0", mem_req_addr, 32'hFFFF_FFFF);
`ifdef INST_PREFETCH_STATS_EN
    check_w("wrap_flush", {16'h0, flush_count}, 32'd4);
`endif
    tick();
    check_w("wrap_addr1", mem_req_addr, 32'h0);
    tick();
    check_w("wrap_out_pc0", out_pc, 32'hFFFF_FFFF);
    check_w("wrap_out_inst0", out_inst, 32'h0);
    tick();
    check_w("wrap_out_pc1", out_pc, 32'h0);
    check_w("wrap_out_inst1", out_inst, 32'hFFFF_FFFF);

    // Fetch disabled: no requests, in-flight word still queued, head retained
    en        = 1'b0;
    out_ready = 1'b0;
    #1;
    check_b("en0_req_valid", mem_req_valid, 1'b0);
    tick();
    check_b("en0_out_valid", out_valid, 1'b1);
    check_w("en0_head_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    tick();
    check_w("en0_inflight_pc", out_pc, 32'h1);
    check_w("en0_inflight_inst", out_inst, inst_of(32'h1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
